usrt_ctrl: RTL

USRT_CTRL -- requirements
Module: usrt_ctrl

---
 rtl/usrt_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/usrt_ctrl.sv
// APB-programmable synchronous serial transmitter: TX FIFO, bit-clock divider, start/8N/stop framing.
// Optional interrupt output enabled with the USRT_CTRL_IRQ_EN macro.
module usrt_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        pClk,
  input  logic        pReset,
  input  logic        pSelect,
  input  logic        pEnable,
  input  logic        pWrite,
  input  logic [32:0] pAddress,
  input  logic [7:0]  pWData,
  output logic [7:0]  pRData,
  output logic        pReady,
  output logic        uClk,
  output logic        uTxd
`ifdef USRT_CTRL_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateT;

  logic rstMeta, rstN;
  logic access, wrAcc, rdAcc, pushReq, push, pop, ctrlWr;
  logic [1:0] addr;
  logic unusedAddr;
  logic enReg, enNext, run, reload, fallTick, ieBit;
  logic [7:0] divReg, divNxt, divCur, divCnt, rdData, shiftReg;
  logic ovf, empty, full, busy;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0] count;
  logic [2:0] bitCnt;
  stateT state, stateNxt;

  // Reset asserts asynchronously, deasserts on the second pClk edge
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      rstMeta <= 1'b0;
      rstN    <= 1'b0;
    end else begin
      rstMeta <= 1'b1;
      rstN    <= rstMeta;
    end
  end

  assign addr       = pAddress[1:0];
  assign unusedAddr = ^pAddress[32:2];
  assign access     = pSelect & pEnable & rstN;
  assign wrAcc      = access & pWrite;
  assign rdAcc      = access & ~pWrite;
  assign pReady     = access;
  assign ctrlWr     = wrAcc & (addr == 2'd2);
  assign pushReq    = wrAcc & (addr == 2'd0);
  assign push       = pushReq & (~full | pop);

  // Abort takes effect on the same edge that commits EN=0
  assign enNext   = ctrlWr ? pWData[0] : enReg;
  assign run      = enReg & enNext;
  assign divNxt   = (wrAcc && addr == 2'd3) ? pWData : divReg;
  assign reload   = run & (divCnt == divCur);
  assign fallTick = reload & uClk;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign busy  = (state != IDLE);

  always_ff @(posedge pClk or negedge rstN) begin
    if (!rstN) begin
      enReg  <= 1'b0;
      divReg <= 8'd0;
      ovf    <= 1'b0;
    end else begin
      enReg  <= enNext;
      divReg <= divNxt;
      if (pushReq && full && !pop)
        ovf <= 1'b1;
      else if (wrAcc && addr == 2'd1 && pWData[3])
        ovf <= 1'b0;
    end
  end

`ifdef USRT_CTRL_IRQ_EN
  logic ieReg;
  always_ff @(posedge pClk or negedge rstN) begin
    if (!rstN) begin
      ieReg <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (ctrlWr) ieReg <= pWData[1];
      irq <= ieReg & empty & ~busy;
    end
  end
  assign ieBit = ieReg;
`else
  assign ieBit = 1'b0;
`endif

  // FIFO storage carries no reset; pointers and count do
  always_ff @(posedge pClk) begin
    if (push) mem[wrPtr] <= pWData;
  end

  always_ff @(posedge pClk or negedge rstN) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Divider reloads from DIV only at a toggle so a half-period is never cut short
  always_ff @(posedge pClk or negedge rstN) begin
    if (!rstN) begin
      divCnt <= 8'd0;
      divCur <= 8'd0;
      uClk   <= 1'b1;
    end else if (!run) begin
      divCnt <= 8'd0;
      divCur <= divNxt;
      uClk   <= 1'b1;
    end else if (reload) begin
      divCnt <= 8'd0;
      divCur <= divNxt;
      uClk   <= ~uClk;
    end else begin
      divCnt <= divCnt + 8'd1;
    end
  end

  always_ff @(posedge pClk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    pop      = 1'b0;
    if (!run) begin
      stateNxt = IDLE;
    end else if (fallTick) begin
      case (state)
        IDLE:  if (!empty) begin pop = 1'b1; stateNxt = START; end
        START: stateNxt = DATA;
        DATA:  if (bitCnt == 3'd7) stateNxt = STOP;
        STOP:  begin
          if (!empty) begin pop = 1'b1; stateNxt = START; end
          else stateNxt = IDLE;
        end
        default: stateNxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge pClk) begin
    if (pop)
      shiftReg <= mem[rdPtr];
    else if (fallTick && (state == START || state == DATA))
      shiftReg <= {1'b0, shiftReg[7:1]};
  end

  // Line output: bit 0 leaves at the START->DATA tick, bitCnt counts the bits already sent after it
  always_ff @(posedge pClk or negedge rstN) begin
    if (!rstN) begin
      uTxd   <= 1'b1;
      bitCnt <= 3'd0;
    end else if (!run) begin
      uTxd   <= 1'b1;
      bitCnt <= 3'd0;
    end else if (fallTick) begin
      case (state)
        IDLE:  uTxd <= ~pop;
        START: begin
          uTxd   <= shiftReg[0];
          bitCnt <= 3'd0;
        end
        DATA:  begin
          if (bitCnt == 3'd7) uTxd <= 1'b1;
          else                uTxd <= shiftReg[0];
          bitCnt <= bitCnt + 3'd1;
        end
        STOP:  uTxd <= ~pop;
        default: uTxd <= 1'b1;
      endcase
    end
  end

  always_comb begin
    rdData = 8'h00;
    case (addr)
      2'd1:    rdData = {4'b0, ovf, busy, full, empty};
      2'd2:    rdData = {6'b0, ieBit, enReg};
      2'd3:    rdData = divReg;
      default: rdData = 8'h00;
    endcase
  end

  assign pRData = rdAcc ? rdData : 8'h00;

endmodule
